// File: rtl/i2c_slave_regs_if.sv
// Register-access strobe interface between the I2C target and external register storage.
// The target drives address/data/strobes and busy; storage returns read data one clk after reg_rd.
interface i2c_slave_regs_if;
   logic [7:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_wr;
   logic       reg_rd;
   logic [7:0] reg_rdata;
   logic       busy;

   modport slave  (output reg_addr, reg_wdata, reg_wr, reg_rd, busy, input reg_rdata);
   modport master (input reg_addr, reg_wdata, reg_wr, reg_rd, busy, output reg_rdata);
endinterface

// File: rtl/i2c_slave_regs.sv
// I2C target with 7-bit address match, register pointer, and auto-incrementing burst
// read/write to external storage through the i2c_slave_regs_if strobe interface.
module i2c_slave_regs #(
   parameter logic [6:0] DEV_ADDR = 7'h76
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_scl,
   inout  wire             io_sda,
   i2c_slave_regs_if.slave bus
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_IGNORE,
      ST_ACK,
      ST_REG,
      ST_WDATA,
      ST_RDATA,
      ST_MACK
   } state_t;

   logic r_sclMeta, r_sclSync, r_sclPrev;
   logic r_sdaMeta, r_sdaSync, r_sdaPrev;

   state_t     r_state;
   state_t     r_ackNext;
   logic [3:0] r_bitCnt;
   logic [7:0] r_shift;
   logic [7:0] r_ptr;
   logic [7:0] r_wdata;
   logic       r_wr;
   logic       r_rd;
   logic       r_busy;
   logic       r_sdaLow;
   logic       r_ackOn;
   logic       r_fetchPend;
   logic       r_incPend;

   logic       w_sclRise, w_sclFall, w_start, w_stop;
   logic [7:0] w_byte;

   // Bus idles high, so the synchronizers reset to 1 to avoid a false edge after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sclMeta <= 1'b1;
         r_sclSync <= 1'b1;
         r_sclPrev <= 1'b1;
         r_sdaMeta <= 1'b1;
         r_sdaSync <= 1'b1;
         r_sdaPrev <= 1'b1;
      end else begin
         r_sclMeta <= i_scl;
         r_sclSync <= r_sclMeta;
         r_sclPrev <= r_sclSync;
         r_sdaMeta <= io_sda;
         r_sdaSync <= r_sdaMeta;
         r_sdaPrev <= r_sdaSync;
      end
   end

   assign w_sclRise = r_sclSync & ~r_sclPrev;
   assign w_sclFall = ~r_sclSync & r_sclPrev;
   assign w_start   = r_sclSync & r_sclPrev & r_sdaPrev & ~r_sdaSync;
   assign w_stop    = r_sclSync & r_sclPrev & ~r_sdaPrev & r_sdaSync;
   assign w_byte    = {r_shift[6:0], r_sdaSync};

   assign io_sda        = r_sdaLow ? 1'b0 : 1'bz;
   assign bus.reg_addr  = r_ptr;
   assign bus.reg_wdata = r_wdata;
   assign bus.reg_wr    = r_wr;
   assign bus.reg_rd    = r_rd;
   assign bus.busy      = r_busy;

   // Fetch capture and post-write increment run beside the FSM so a START/STOP cannot lose them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_ackNext   <= ST_IDLE;
         r_bitCnt    <= 4'd0;
         r_shift     <= 8'd0;
         r_ptr       <= 8'd0;
         r_wdata     <= 8'd0;
         r_wr        <= 1'b0;
         r_rd        <= 1'b0;
         r_busy      <= 1'b0;
         r_sdaLow    <= 1'b0;
         r_ackOn     <= 1'b0;
         r_fetchPend <= 1'b0;
         r_incPend   <= 1'b0;
      end else begin
         r_wr        <= 1'b0;
         r_rd        <= 1'b0;
         r_fetchPend <= r_rd;
         if (r_fetchPend) r_shift <= bus.reg_rdata;
         if (r_incPend) begin
            r_ptr     <= r_ptr + 8'd1;
            r_incPend <= 1'b0;
         end

         if (w_start) begin
            r_state  <= ST_ADDR;
            r_bitCnt <= 4'd0;
            r_sdaLow <= 1'b0;
            r_ackOn  <= 1'b0;
         end else if (w_stop) begin
            r_state  <= ST_IDLE;
            r_sdaLow <= 1'b0;
            r_ackOn  <= 1'b0;
            r_busy   <= 1'b0;
         end else begin
            case (r_state)
               ST_ADDR, ST_REG, ST_WDATA: begin
                  if (w_sclRise) begin
                     r_shift  <= w_byte;
                     r_bitCnt <= r_bitCnt + 4'd1;
                     if (r_bitCnt == 4'd7) begin
                        r_bitCnt <= 4'd0;
                        r_ackOn  <= 1'b0;
                        r_state  <= ST_ACK;
                        if (r_state == ST_ADDR) begin
                           if (w_byte[7:1] == DEV_ADDR) begin
                              r_busy    <= 1'b1;
                              r_ackNext <= w_byte[0] ? ST_RDATA : ST_REG;
                              r_rd      <= w_byte[0];
                           end else begin
                              r_busy  <= 1'b0;
                              r_state <= ST_IGNORE;
                           end
                        end else if (r_state == ST_REG) begin
                           r_ptr     <= w_byte;
                           r_ackNext <= ST_WDATA;
                        end else begin
                           r_wr      <= 1'b1;
                           r_wdata   <= w_byte;
                           r_incPend <= 1'b1;
                           r_ackNext <= ST_WDATA;
                        end
                     end
                  end
               end
               ST_ACK: begin
                  if (w_sclFall) begin
                     if (!r_ackOn) begin
                        r_sdaLow <= 1'b1;
                        r_ackOn  <= 1'b1;
                     end else begin
                        r_ackOn  <= 1'b0;
                        r_state  <= r_ackNext;
                        r_bitCnt <= 4'd0;
                        r_sdaLow <= 1'b0;
                        // The fall that ends our ACK is also the launch edge of the first read bit.
                        if (r_ackNext == ST_RDATA) begin
                           r_sdaLow <= ~r_shift[7];
                           r_shift  <= {r_shift[6:0], 1'b0};
                           r_bitCnt <= 4'd1;
                        end
                     end
                  end
               end
               ST_RDATA: begin
                  if (w_sclFall) begin
                     if (r_bitCnt == 4'd8) begin
                        r_sdaLow <= 1'b0;
                        r_bitCnt <= 4'd0;
                        r_state  <= ST_MACK;
                     end else begin
                        r_sdaLow <= ~r_shift[7];
                        r_shift  <= {r_shift[6:0], 1'b0};
                        r_bitCnt <= r_bitCnt + 4'd1;
                     end
                  end
               end
               ST_MACK: begin
                  if (w_sclRise) begin
                     r_bitCnt <= 4'd0;
                     if (!r_sdaSync) begin
                        r_ptr   <= r_ptr + 8'd1;
                        r_rd    <= 1'b1;
                        r_state <= ST_RDATA;
                     end else begin
                        r_state <= ST_IGNORE;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
